// File: rtl/wb_result_stage.sv
// Writeback result stage: source select, optional load extension (`WB_LOAD_EXT_EN`),
// and MEM-stage stall while variable-latency load data is outstanding.
module wb_result_stage #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_SRC    = 4,
   parameter int SEL_WIDTH  = $clog2(NUM_SRC),
   parameter int LOAD_IDX   = 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          ValidM,
   input  logic                          RegWriteM,
   input  logic [4:0]                    RdM,
   input  logic [SEL_WIDTH-1:0]          ResultSrcM,
   input  logic [NUM_SRC*DATA_WIDTH-1:0] SrcDataM,
   input  logic [2:0]                    LoadTypeM,
   input  logic [1:0]                    AddrLoM,
   input  logic                          ReadValidM,
   input  logic                          FlushW,
   output logic                          StallM,
   output logic                          ValidW,
   output logic                          RegWriteW,
   output logic [4:0]                    RdW,
   output logic [DATA_WIDTH-1:0]         ResultW
);

   typedef enum logic {RUN, WAIT_LOAD} state_t;

   state_t                state, state_next;
   logic                  valid_next, we_next, stall, capture;
   logic [4:0]            rd_next, pend_rd;
   logic                  pend_we;
   logic [DATA_WIDTH-1:0] result_next, sel_data, load_raw;
   logic [DATA_WIDTH-1:0] hit_load_data, wait_load_data;
   logic                  in_range, is_load;

   assign load_raw = SrcDataM[LOAD_IDX*DATA_WIDTH +: DATA_WIDTH];
   assign is_load  = ValidM && (ResultSrcM == SEL_WIDTH'(LOAD_IDX));

`ifdef WB_LOAD_EXT_EN
   logic [2:0] pend_type;
   logic [1:0] pend_lo;

   function automatic logic [DATA_WIDTH-1:0] extend_load(
      input logic [DATA_WIDTH-1:0] raw,
      input logic [2:0]            ltype,
      input logic [1:0]            alo
   );
      logic [7:0]  b;
      logic [15:0] h;
      case (alo)
         2'd0:    b = raw[7:0];
         2'd1:    b = raw[15:8];
         2'd2:    b = raw[23:16];
         default: b = raw[31:24];
      endcase
      h = alo[1] ? raw[31:16] : raw[15:0];
      case (ltype)
         3'b000:  extend_load = {{(DATA_WIDTH-8){b[7]}}, b};
         3'b001:  extend_load = {{(DATA_WIDTH-16){h[15]}}, h};
         3'b100:  extend_load = {{(DATA_WIDTH-8){1'b0}}, b};
         3'b101:  extend_load = {{(DATA_WIDTH-16){1'b0}}, h};
         default: extend_load = raw;
      endcase
   endfunction

   assign hit_load_data  = extend_load(load_raw, LoadTypeM, AddrLoM);
   assign wait_load_data = extend_load(load_raw, pend_type, pend_lo);

   // The load's extension controls must survive the wait, like rd.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_type <= 3'b010;
         pend_lo   <= 2'd0;
      end else if (capture) begin
         pend_type <= LoadTypeM;
         pend_lo   <= AddrLoM;
      end
   end
`else
   logic unused_load_ctl;
   assign unused_load_ctl = ^{LoadTypeM, AddrLoM};
   assign hit_load_data   = load_raw;
   assign wait_load_data  = load_raw;
`endif

   // Loop mux keeps an out-of-range select from indexing past SrcDataM.
   always_comb begin
      sel_data = '0;
      in_range = 1'b0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (ResultSrcM == SEL_WIDTH'(k)) begin
            sel_data = SrcDataM[k*DATA_WIDTH +: DATA_WIDTH];
            in_range = 1'b1;
         end
      end
   end

   always_comb begin
      state_next  = state;
      valid_next  = 1'b0;
      we_next     = 1'b0;
      rd_next     = RdW;
      result_next = ResultW;
      stall       = 1'b0;
      capture     = 1'b0;
      if (FlushW) begin
         state_next = RUN;
      end else begin
         case (state)
            RUN: begin
               if (is_load && !ReadValidM) begin
                  stall      = 1'b1;
                  capture    = 1'b1;
                  state_next = WAIT_LOAD;
               end else if (ValidM) begin
                  valid_next  = 1'b1;
                  rd_next     = RdM;
                  we_next     = RegWriteM && (RdM != 5'd0) && in_range;
                  if (!in_range)
                     result_next = '0;
                  else if (is_load)
                     result_next = hit_load_data;
                  else
                     result_next = sel_data;
               end
            end
            WAIT_LOAD: begin
               if (ReadValidM) begin
                  state_next  = RUN;
                  valid_next  = 1'b1;
                  rd_next     = pend_rd;
                  we_next     = pend_we && (pend_rd != 5'd0);
                  result_next = wait_load_data;
               end else begin
                  stall = 1'b1;
               end
            end
            default: state_next = RUN;
         endcase
      end
   end

   assign StallM = stall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= RUN;
         ValidW    <= 1'b0;
         RegWriteW <= 1'b0;
         RdW       <= 5'd0;
         ResultW   <= '0;
         pend_rd   <= 5'd0;
         pend_we   <= 1'b0;
      end else begin
         state     <= state_next;
         ValidW    <= valid_next;
         RegWriteW <= we_next;
         RdW       <= rd_next;
         ResultW   <= result_next;
         if (capture) begin
            pend_rd <= RdM;
            pend_we <= RegWriteM;
         end
      end
   end

endmodule

// File: tb/tb_wb_result_stage.sv
// Directed self-checking bench for wb_result_stage; a second instance with
// NUM_SRC=3 covers the out-of-range select.
module tb_wb_result_stage;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         valid, reg_write, read_valid, flush;
   logic [4:0]   rd;
   logic [1:0]   sel;
   logic [127:0] src_data;
   logic [2:0]   load_type;
   logic [1:0]   addr_lo;

   logic         stall, valid_w, we_w;
   logic [4:0]   rd_w;
   logic [31:0]  result_w;
   logic         stall3, valid_w3, we_w3;
   logic [4:0]   rd_w3;
   logic [31:0]  result_w3;

   int checks = 0;
   int errors = 0;

`ifdef WB_LOAD_EXT_EN
   localparam logic [31:0] EXP_LB  = 32'hFFFFFF80;
   localparam logic [31:0] EXP_LHU = 32'h0000BEEF;
   localparam logic [31:0] EXP_LH  = 32'hFFFF8001;
`else
   localparam logic [31:0] EXP_LB  = 32'h00800000;
   localparam logic [31:0] EXP_LHU = 32'hBEEF0000;
   localparam logic [31:0] EXP_LH  = 32'h00008001;
`endif

   always #5 clk = ~clk;

   wb_result_stage dut (
      .clk(clk), .rst_n(rst_n), .ValidM(valid), .RegWriteM(reg_write), .RdM(rd),
      .ResultSrcM(sel), .SrcDataM(src_data), .LoadTypeM(load_type), .AddrLoM(addr_lo),
      .ReadValidM(read_valid), .FlushW(flush), .StallM(stall), .ValidW(valid_w),
      .RegWriteW(we_w), .RdW(rd_w), .ResultW(result_w)
   );

   wb_result_stage #(.NUM_SRC(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .ValidM(valid), .RegWriteM(reg_write), .RdM(rd),
      .ResultSrcM(sel), .SrcDataM(src_data[95:0]), .LoadTypeM(load_type), .AddrLoM(addr_lo),
      .ReadValidM(read_valid), .FlushW(flush), .StallM(stall3), .ValidW(valid_w3),
      .RegWriteW(we_w3), .RdW(rd_w3), .ResultW(result_w3)
   );

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
      end
   endtask

   // The chosen slot gets the payload; the others carry recognisable filler.
   task automatic applyStimulus(input logic v, input logic we, input logic [4:0] r,
                                input logic [1:0] s, input logic [31:0] d,
                                input logic [2:0] lt, input logic [1:0] alo,
                                input logic rv, input logic fl);
      logic [127:0] words;
      words = {32'hDEAD0003, 32'hDEAD0002, 32'hDEAD0001, 32'hDEAD0000};
      words[s*32 +: 32] = d;
      valid = v; reg_write = we; rd = r; sel = s; src_data = words;
      load_type = lt; addr_lo = alo; read_valid = rv; flush = fl;
   endtask

   task automatic stepClock();
      @(posedge clk);
      #1;
   endtask

   task automatic applyIdle();
      applyStimulus(1'b0, 1'b0, 5'd0, 2'd0, 32'h0, 3'b010, 2'd0, 1'b0, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0;
      applyIdle();
      #12;
      checkOutput("rst_valid", valid_w, 1'b0);
      checkOutput("rst_we", we_w, 1'b0);
      checkOutput("rst_rd", rd_w, 5'd0);
      checkOutput("rst_result", result_w, 32'h0);
      checkOutput("rst_stall", stall, 1'b0);
      rst_n = 1'b1;
      stepClock();
      stepClock();
      checkOutput("post_rst_valid", valid_w, 1'b0);
      checkOutput("post_rst_result", result_w, 32'h0);
      checkOutput("post_rst_stall", stall, 1'b0);

      // Back-to-back ALU, PC+4, immediate
      applyStimulus(1'b1, 1'b1, 5'd5, 2'd0, 32'h12345678, 3'b010, 2'd0, 1'b0, 1'b0);
      #1 checkOutput("alu_stall", stall, 1'b0);
      stepClock();
      checkOutput("alu_valid", valid_w, 1'b1);
      checkOutput("alu_rd", rd_w, 5'd5);
      checkOutput("alu_we", we_w, 1'b1);
      checkOutput("alu_result", result_w, 32'h12345678);
      applyStimulus(1'b1, 1'b1, 5'd1, 2'd2, 32'h00000104, 3'b010, 2'd0, 1'b0, 1'b0);
      stepClock();
      checkOutput("pc4_valid", valid_w, 1'b1);
      checkOutput("pc4_rd", rd_w, 5'd1);
      checkOutput("pc4_we", we_w, 1'b1);
      checkOutput("pc4_result", result_w, 32'h00000104);
      applyStimulus(1'b1, 1'b1, 5'd7, 2'd3, 32'hFFFFF000, 3'b010, 2'd0, 1'b0, 1'b0);
      stepClock();
      checkOutput("imm_valid", valid_w, 1'b1);
      checkOutput("imm_rd", rd_w, 5'd7);
      checkOutput("imm_we", we_w, 1'b1);
      checkOutput("imm_result", result_w, 32'hFFFFF000);
      applyIdle();
      stepClock();
      checkOutput("pulse_valid", valid_w, 1'b0);
      checkOutput("pulse_we", we_w, 1'b0);

      // LB at offset 2 with three wait cycles
      applyStimulus(1'b1, 1'b1, 5'd9, 2'd1, 32'h00800000, 3'b000, 2'd2, 1'b0, 1'b0);
      #1 checkOutput("lb_stall1", stall, 1'b1);
      stepClock();
      checkOutput("lb_wait_valid1", valid_w, 1'b0);
      checkOutput("lb_stall2", stall, 1'b1);
      stepClock();
      checkOutput("lb_wait_valid2", valid_w, 1'b0);
      checkOutput("lb_stall3", stall, 1'b1);
      stepClock();
      applyStimulus(1'b1, 1'b1, 5'd9, 2'd1, 32'h00800000, 3'b000, 2'd2, 1'b1, 1'b0);
      #1 checkOutput("lb_stall_end", stall, 1'b0);
      checkOutput("lb_wait_valid3", valid_w, 1'b0);
      stepClock();
      checkOutput("lb_valid", valid_w, 1'b1);
      checkOutput("lb_rd", rd_w, 5'd9);
      checkOutput("lb_we", we_w, 1'b1);
      checkOutput("lb_result", result_w, EXP_LB);

      // Load hits: LHU at offset 2, LH at offset 0
      applyStimulus(1'b1, 1'b1, 5'd10, 2'd1, 32'hBEEF0000, 3'b101, 2'd2, 1'b1, 1'b0);
      #1 checkOutput("lhu_stall", stall, 1'b0);
      stepClock();
      checkOutput("lhu_valid", valid_w, 1'b1);
      checkOutput("lhu_result", result_w, EXP_LHU);
      applyStimulus(1'b1, 1'b1, 5'd11, 2'd1, 32'h00008001, 3'b001, 2'd0, 1'b1, 1'b0);
      stepClock();
      checkOutput("lh_rd", rd_w, 5'd11);
      checkOutput("lh_result", result_w, EXP_LH);

      // rd=0 suppression; out-of-range select on the 3-source instance
      applyStimulus(1'b1, 1'b1, 5'd0, 2'd0, 32'h00000055, 3'b010, 2'd0, 1'b0, 1'b0);
      stepClock();
      checkOutput("rd0_valid", valid_w, 1'b1);
      checkOutput("rd0_we", we_w, 1'b0);
      checkOutput("rd0_result", result_w, 32'h00000055);
      applyStimulus(1'b1, 1'b1, 5'd4, 2'd3, 32'hCAFEF00D, 3'b010, 2'd0, 1'b0, 1'b0);
      stepClock();
      checkOutput("oor_valid", valid_w3, 1'b1);
      checkOutput("oor_we", we_w3, 1'b0);
      checkOutput("oor_result", result_w3, 32'h0);
      checkOutput("inrange4_we", we_w, 1'b1);
      checkOutput("inrange4_result", result_w, 32'hCAFEF00D);

      // Flush during a load wait
      applyStimulus(1'b1, 1'b1, 5'd12, 2'd1, 32'h11223344, 3'b010, 2'd0, 1'b0, 1'b0);
      stepClock();
      checkOutput("fl_wait_stall", stall, 1'b1);
      applyStimulus(1'b1, 1'b1, 5'd12, 2'd1, 32'h11223344, 3'b010, 2'd0, 1'b0, 1'b1);
      #1 checkOutput("fl_stall", stall, 1'b0);
      stepClock();
      checkOutput("fl_valid", valid_w, 1'b0);
      checkOutput("fl_we", we_w, 1'b0);
      applyStimulus(1'b0, 1'b0, 5'd0, 2'd1, 32'h11223344, 3'b010, 2'd0, 1'b1, 1'b0);
      #1 checkOutput("fl_after_stall", stall, 1'b0);
      stepClock();
      checkOutput("fl_late_valid", valid_w, 1'b0);
      checkOutput("fl_late_we", we_w, 1'b0);

      // Reset during a load wait
      applyStimulus(1'b1, 1'b1, 5'd13, 2'd1, 32'h55667788, 3'b010, 2'd0, 1'b0, 1'b0);
      stepClock();
      checkOutput("rw_wait_stall", stall, 1'b1);
      rst_n = 1'b0;
      applyIdle();
      #1 checkOutput("rw_stall", stall, 1'b0);
      checkOutput("rw_valid", valid_w, 1'b0);
      checkOutput("rw_rd", rd_w, 5'd0);
      stepClock();
      rst_n = 1'b1;
      applyStimulus(1'b0, 1'b0, 5'd0, 2'd1, 32'h55667788, 3'b010, 2'd0, 1'b1, 1'b0);
      #1 checkOutput("rw_after_stall", stall, 1'b0);
      stepClock();
      checkOutput("rw_late_valid", valid_w, 1'b0);
      checkOutput("rw_late_we", we_w, 1'b0);
      checkOutput("rw_late_result", result_w, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
